// File: rtl/riscv_dii_arbiter.sv
// Packet-granular round-robin arbiter merging PORTS DII flit streams into one stream.
// Define RISCV_DII_ARB_PKTCNT_EN to add per-port completed-packet counters (pkt_count).
module riscv_dii_arbiter #(
    parameter int XLEN      = 64,
    parameter int PORTS     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PORTS*XLEN-1:0]      in_data,
    input  logic [PORTS-1:0]           in_last,
    input  logic [PORTS-1:0]           in_valid,
    output logic [PORTS-1:0]           in_ready,
    output logic [XLEN-1:0]            out_data,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PORTS-1:0]           grant,
`ifdef RISCV_DII_ARB_PKTCNT_EN
    output logic                       busy,
    output logic [PORTS*CNT_WIDTH-1:0] pkt_count
`else
    output logic                       busy
`endif
);

    localparam int SEL_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   prio_q, prio_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [PORTS-1:0]   grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               fire;

    generate
        if (PORTS < 1 || CNT_WIDTH < 1) begin : g_bad_param
            $error("riscv_dii_arbiter: PORTS and CNT_WIDTH must be >= 1");
        end
    endgenerate

    // Zero-latency pass-through from the locked port; everything idles low otherwise.
    always_comb begin
        out_data  = '0;
        out_last  = 1'b0;
        out_valid = 1'b0;
        in_ready  = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (state_q == LOCKED && sel_q == SEL_W'(i)) begin
                out_data    = in_data[i*XLEN +: XLEN];
                out_last    = in_last[i];
                out_valid   = in_valid[i];
                in_ready[i] = out_ready;
            end
        end
    end

    assign fire = out_valid & out_ready & out_last;

    always_comb begin
        int  idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        state_d = state_q;
        prio_d  = prio_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                for (int k = 0; k < PORTS; k++) begin
                    idx = int'(prio_q) + k;
                    if (idx >= PORTS) idx = idx - PORTS;
                    if (!found && in_valid[idx]) begin
                        found   = 1'b1;
                        sel_d   = SEL_W'(idx);
                        grant_d = PORTS'(1) << idx;
                        busy_d  = 1'b1;
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (fire) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    grant_d = '0;
                    prio_d  = (sel_q == SEL_W'(PORTS - 1)) ? '0 : sel_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;

`ifdef RISCV_DII_ARB_PKTCNT_EN
    logic [PORTS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < PORTS; i++) begin
            if (fire && sel_q == SEL_W'(i)) cnt_d[i] = cnt_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign pkt_count = cnt_q;
`endif

endmodule

// File: tb/tb_riscv_dii_arbiter.sv
// Self-checking bench for riscv_dii_arbiter: directed packet scenarios plus random traffic,
// every cycle compared against a packet-level reference model.
module tb_riscv_dii_arbiter;

    localparam int P  = 4;
    localparam int XW = 64;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [P*XW-1:0] in_data = '0;
    logic [P-1:0]    in_last = '0;
    logic [P-1:0]    in_valid = '0;
    logic [P-1:0]    in_ready;
    logic [XW-1:0]   out_data;
    logic            out_last;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [P-1:0]    grant;
    logic            busy;
`ifdef RISCV_DII_ARB_PKTCNT_EN
    logic [P*CW-1:0] pkt_count;
`endif

    riscv_dii_arbiter #(.XLEN(XW), .PORTS(P), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant     (grant),
`ifdef RISCV_DII_ARB_PKTCNT_EN
        .busy      (busy),
        .pkt_count (pkt_count)
`else
        .busy      (busy)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner = port holding the packet lock (-1 when idle), rr = next search start
    int               owner = -1;
    int               rr    = 0;
    int               cyc   = 0;
    int unsigned      cnt[P];
    int               grant_log[$];
    int               grant_cyc[$];
    logic [XW-1:0]    xfer_log[$];

    // Packet sources for directed tests
    bit               use_src = 1'b0;
    logic [P-1:0]     src_on = '0;
    logic [P-1:0]     hold = '0;
    int               src_len[P];
    int               src_pos[P];
    int               src_left[P];
    logic [XW-1:0]    src_base[P];

    task automatic src_set(input int p, input int len, input int left, input logic [XW-1:0] base);
        src_len[p]  = len;
        src_left[p] = left;
        src_pos[p]  = 0;
        src_base[p] = base;
        src_on[p]   = 1'b1;
    endtask

    task automatic apply_src();
        for (int p = 0; p < P; p++) begin
            in_valid[p] = src_on[p] & ~hold[p];
            in_last[p]  = (src_pos[p] == src_len[p] - 1);
            in_data[p*XW +: XW] = src_base[p] + XW'(src_pos[p] + 1);
        end
    endtask

    task automatic check_outputs();
        logic [P-1:0]  eg;
        logic [P-1:0]  er;
        logic [XW-1:0] ed;
        logic          el;
        logic          ev;
        eg = '0; er = '0; ed = '0; el = 1'b0; ev = 1'b0;
        if (owner >= 0) begin
            eg[owner] = 1'b1;
            ev = in_valid[owner];
            el = in_last[owner];
            ed = in_data[owner*XW +: XW];
            if (out_ready) er = eg;
        end
        check_val("grant", grant, eg);
        check_val("busy", busy, owner >= 0);
        check_val("out_valid", out_valid, ev);
        check_val("out_last", out_last, el);
        check_val("out_data", out_data, ed);
        check_val("in_ready", in_ready, er);
`ifdef RISCV_DII_ARB_PKTCNT_EN
        for (int p = 0; p < P; p++) check_val("pkt_count", pkt_count[p*CW +: CW], 64'(cnt[p]));
`endif
    endtask

    // Check at negedge+1, advance model across the posedge, return at the next negedge.
    task automatic tick();
        #1 check_outputs();
        @(posedge clk);
        cyc++;
        if (rst) begin
            owner = -1;
            rr = 0;
            for (int p = 0; p < P; p++) begin
                cnt[p] = 0;
                src_pos[p] = 0;
            end
        end else if (owner < 0) begin
            for (int k = 0; k < P; k++) begin
                if (in_valid[(rr + k) % P]) begin
                    owner = (rr + k) % P;
                    grant_log.push_back(owner);
                    grant_cyc.push_back(cyc);
                    break;
                end
            end
        end else if (in_valid[owner] && out_ready) begin
            xfer_log.push_back(in_data[owner*XW +: XW]);
            if (in_last[owner]) begin
                cnt[owner] = (cnt[owner] + 1) % (1 << CW);
                rr = (owner + 1) % P;
                if (use_src) begin
                    src_pos[owner] = 0;
                    src_left[owner]--;
                    if (src_left[owner] == 0) src_on[owner] = 1'b0;
                end
                owner = -1;
            end else if (use_src) begin
                src_pos[owner]++;
            end
        end
        @(negedge clk);
        if (use_src) apply_src();
    endtask

    task automatic run_until_done(input string tag);
        for (int n = 0; n < 80 && src_on != '0; n++) tick();
        check_val(tag, src_on, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int exp2[5];
        exp2 = '{0, 1, 2, 3, 0};
        @(posedge clk);
        @(negedge clk);
        do_reset();

        // 3-flit packet on port 2
        use_src = 1'b1; out_ready = 1'b1; src_on = '0; hold = '0;
        xfer_log.delete(); grant_log.delete();
        src_set(2, 3, 1, 64'hA0);
        apply_src();
        tick();
        #1 check_val("t1_grant", grant, 4'b0100);
        run_until_done("t1_done");
        #1 check_val("t1_busy_after", busy, 1'b0);
        check_val("t1_nflits", xfer_log.size(), 3);
        if (xfer_log.size() == 3) begin
            check_val("t1_f1", xfer_log[0], 64'hA1);
            check_val("t1_f2", xfer_log[1], 64'hA2);
            check_val("t1_f3", xfer_log[2], 64'hA3);
        end
        // prio now 3: all ports requesting must pick port 3
        use_src = 1'b0; in_valid = '1; in_last = '1;
        tick();
        #1 check_val("t1_prio3", grant, 4'b1000);
        in_valid = 4'b1000;
        tick();
        in_valid = '0;
        tick();

        // Fairness: all ports with 2-flit packets
        do_reset();
        use_src = 1'b1; src_on = '0;
        grant_log.delete(); grant_cyc.delete();
        src_set(0, 2, 2, 64'h1000);
        src_set(1, 2, 1, 64'h2000);
        src_set(2, 2, 1, 64'h3000);
        src_set(3, 2, 1, 64'h4000);
        apply_src();
        run_until_done("t2_done");
        check_val("t2_ngrants", grant_log.size(), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
            check_val("t2_order", grant_log[i], exp2[i]);
            if (i > 0) check_val("t2_spacing", grant_cyc[i] - grant_cyc[i-1], 3);
        end

        // Mid-packet valid drop on port 1 while port 0 requests
        do_reset();
        src_on = '0; grant_log.delete(); xfer_log.delete();
        src_set(1, 3, 1, 64'hB0);
        apply_src();
        tick();
        tick();
        src_set(0, 1, 1, 64'hC0);
        hold = 4'b0010;
        apply_src();
        for (int n = 0; n < 5; n++) begin
            #1 check_val("t3_grant", grant, 4'b0010);
            check_val("t3_rdy0", in_ready[0], 1'b0);
            tick();
        end
        hold = '0;
        apply_src();
        run_until_done("t3_done");
        check_val("t3_ngrants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check_val("t3_g0", grant_log[0], 1);
            check_val("t3_g1", grant_log[1], 0);
        end
        check_val("t3_nflits", xfer_log.size(), 4);
        if (xfer_log.size() == 4) begin
            check_val("t3_f1", xfer_log[0], 64'hB1);
            check_val("t3_f2", xfer_log[1], 64'hB2);
            check_val("t3_f3", xfer_log[2], 64'hB3);
            check_val("t3_f4", xfer_log[3], 64'hC1);
        end

        // Single-flit on port 3 with backpressure
        do_reset();
        src_on = '0; grant_log.delete();
        out_ready = 1'b0;
        src_set(3, 1, 1, 64'hD0);
        apply_src();
        tick();
        for (int n = 0; n < 2; n++) begin
            #1 check_val("t4_rdy3_low", in_ready[3], 1'b0);
            tick();
        end
        src_set(0, 1, 1, 64'hE0);
        out_ready = 1'b1;
        apply_src();
        #1 check_val("t4_rdy3_high", in_ready[3], 1'b1);
        tick();
        #1 check_val("t4_released", busy, 1'b0);
        tick();
        #1 check_val("t4_next_grant", grant, 4'b0001);
        run_until_done("t4_done");

        // Reset during flit 2 of a 4-flit packet (prio is 1 going in)
        src_on = '0;
        src_set(2, 4, 1, 64'hF0);
        apply_src();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1 check_val("t5_busy", busy, 1'b0);
        check_val("t5_grant", grant, '0);
        check_val("t5_in_ready", in_ready, '0);
        src_set(0, 1, 1, 64'h70);
        apply_src();
        tick();
        #1 check_val("t5_prio0", grant, 4'b0001);
        run_until_done("t5_done");

        // Five single-flit packets on port 0 (counter wraps when enabled)
        do_reset();
        src_on = '0;
        src_set(0, 1, 5, 64'h50);
        apply_src();
        run_until_done("t6_done");
        tick();
`ifdef RISCV_DII_ARB_PKTCNT_EN
        #1 check_val("t6_cnt0", pkt_count[CW-1:0], 1);
        check_val("t6_cnt_others", pkt_count[P*CW-1:CW], '0);
`endif

        // Random traffic
        use_src = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(63) == 0);
            in_valid  = P'($urandom);
            in_last   = P'($urandom) & P'($urandom);
            out_ready = ($urandom_range(3) != 0);
            for (int p = 0; p < P; p++) in_data[p*XW +: XW] = {$urandom, $urandom};
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_dii_arbiter.md
# riscv_dii_arbiter

Packet-granular round-robin arbiter that merges `PORTS` debug-interconnect (DII) flit streams into one DII stream. It sits in front of the host-interface module's DII egress input, so several debug modules share the single GLIP path to the host. A grant is held from a packet's first flit through its `last` flit, so packets are never interleaved.

## Interface
- `XLEN`, 64, flit width in bits.
- `PORTS`, 4, number of requesting DII input streams (≥1).
- `CNT_WIDTH`, 16, width of each per-port packet counter; used only with `RISCV_DII_ARB_PKTCNT_EN`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_data` in PORTS*XLEN: flit data; port i occupies bits [i*XLEN +: XLEN].
- `in_last` in PORTS: last flit of packet, per port.
- `in_valid` in PORTS: flit valid, per port.
- `in_ready` out PORTS: flit accepted, per port.
- `out_data` out XLEN: merged flit data.
- `out_last` out 1: merged last flag.
- `out_valid` out 1: merged valid.
- `out_ready` in 1: downstream ready.
- `grant` out PORTS: one-hot current owner; all zero when idle.
- `busy` out 1: high while the arbiter is in LOCKED.
- `pkt_count` out PORTS*CNT_WIDTH: completed-packet count per port; present only with the macro.

## Operation
- FSM has two states, IDLE and LOCKED. Reset state is IDLE, with pointer `prio` = 0.
- **IDLE**
  - Round-robin search over `in_valid`, starting at index `prio` and ascending modulo PORTS.
  - The first set index is registered into `sel`. `grant` = onehot(sel) and the state moves to LOCKED on the next edge.
  - With no valid input, the state stays IDLE.
  - No flit is transferred in IDLE: `in_ready` = 0, `out_valid` = 0.
- **LOCKED**
  - `out_data`, `out_last`, `out_valid` pass combinationally from port `sel`.
  - `in_ready[sel]` = `out_ready`. All other `in_ready` bits are 0.
  - When `out_valid & out_ready & out_last`, the state returns to IDLE and `prio` ← (sel+1) mod PORTS.
- **Mid-packet valid drop:** if `in_valid[sel]` deasserts mid-packet, the arbiter stays LOCKED indefinitely. There is no timeout.
- **Output values outside LOCKED:** when not LOCKED, `out_data` = 0 and `out_last` = 0.
- **Single-flit packet:** a flit with `valid & last` releases the lock on the same edge it transfers.
- **PORTS=1:** `prio` is constant 0; behaviour is otherwise identical.
- **Request changes:** requests that change while LOCKED do not affect the current grant.
- **Reset mid-packet:** the lock is abandoned, the state returns to IDLE and `prio` to 0. The upstream source sees `in_ready` low and must restart its packet.

## Timing
- **Reset values:** `grant` = 0, `busy` = 0, `out_valid` = 0, `out_last` = 0, `out_data` = 0, `in_ready` = 0, `pkt_count` = 0.
- **Arbitration latency:** `in_valid` sampled in IDLE at cycle N gives `grant` and `busy` high in cycle N+1. The first flit can transfer in cycle N+1.
- **Data path:** zero-cycle combinational path from input to output while LOCKED. No buffering inside the block.
- **Packet throughput:** one idle bubble cycle between consecutive packets. An L-flit packet with continuous ready occupies L+1 cycles.
- **Handshake:** valid/ready as on all DII links. A transfer occurs only when valid and ready are both high at a rising edge. `in_ready[sel]` may depend combinationally on `out_ready`.
- **Fairness:** with all ports continuously requesting, grants cycle 0,1,2,…,PORTS-1,0.

## Configuration
- Macro: `RISCV_DII_ARB_PKTCNT_EN`.
- **Defined:**
  - Port `pkt_count` exists.
  - Counter i increments by 1 on every `out_valid & out_ready & out_last` while `sel` = i.
  - Counters wrap from 2^CNT_WIDTH−1 to 0 and reset to 0.
- **Undefined:** port `pkt_count` and the counters are absent. Arbitration behaviour is identical.

## Test plan
- Reset, then port 2 sends a 3-flit packet (0xA1, 0xA2, 0xA3+last) with `out_ready`=1 → `grant`=4'b0100 one cycle after valid. Output shows 0xA1..0xA3 on 3 consecutive cycles, then `busy`=0 and `prio`=3.
- All 4 ports hold 2-flit packets continuously → grant order 0,1,2,3,0. Each packet takes 3 cycles. No flits interleave.
- Port 1 is granted and `in_valid[1]` drops for 5 cycles mid-packet while port 0 is valid → `grant` stays 4'b0010, `in_ready[0]`=0, and the packet completes intact.
- Single-flit packet on port 3 with `out_ready` low for 2 cycles → `in_ready[3]` low for 2 cycles, then transfer. Release happens on the same edge; the next grant goes to port 0.
- Assert `rst` during flit 2 of a 4-flit packet → next cycle `busy`=0, `grant`=0, `in_ready`=0, `prio`=0.
- With `RISCV_DII_ARB_PKTCNT_EN`, `CNT_WIDTH`=2: send 5 packets on port 0 → `pkt_count[0]` reads 1,2,3,0,1. Other counters stay 0.
